wptr_full: RTL
==============

WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter ASIZE, default 4: address width; FIFO depth is 2^ASIZE entries.
REQ-002 Parameter AFULL_THRESH, default 2^ASIZE-2: fill level at or above which walmost_full SHALL assert.
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 wrst  input  1  reset, asynchronous, active-high.
REQ-005 winc  input  1  write request for the current cycle.
REQ-006 RSW2_ptr  input  ASIZE+1  read Gray pointer, already synchronized (2-flop) into wclk domain.
REQ-007 woverflow_clr  input  1  clears sticky overflow flag.
REQ-008 wptr  output  ASIZE+1  registered write Gray pointer, sent to the read-domain synchronizer.
REQ-009 waddr  output  ASIZE  memory write address, equal to wbin[ASIZE-1:0].
REQ-010 wen  output  1  memory write enable, combinational winc & ~wfull.
REQ-011 wfull  output  1  registered full flag.
REQ-012 walmost_full  output  1  registered almost-full flag.
REQ-013 wlevel  output  ASIZE+1  registered fill level, range 0..2^ASIZE.
REQ-014 woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-015 Internal binary pointer wbin, ASIZE+1 bits; wbinnext = wbin + (winc & ~wfull), modulo 2^(ASIZE+1).
REQ-016 wgraynext = (wbinnext >> 1) ^ wbinnext; every edge registers wbin <= wbinnext and wptr <= wgraynext.
REQ-017 Consecutive wptr values SHALL differ in exactly one bit, including the wrap from binary 2^(ASIZE+1)-1 to 0.
REQ-018 wfull_next = (wgraynext == {~RSW2_ptr[ASIZE:ASIZE-1], RSW2_ptr[ASIZE-2:0]}); wfull <= wfull_next each edge.
REQ-019 wfull SHALL assert on the same edge that accepts the 2^ASIZE-th outstanding write (no lag cycle).
REQ-020 A write with wfull=1 SHALL be dropped: wen=0, and wbin, wptr and waddr hold.
REQ-021 rbin_s = Gray-to-binary of RSW2_ptr (MSB passthrough, XOR cascade downward), combinational.
REQ-022 wlevel <= wbinnext - rbin_s, modulo 2^(ASIZE+1); the result SHALL never exceed 2^ASIZE.
REQ-023 walmost_full <= (wbinnext - rbin_s) >= AFULL_THRESH, registered on the same edge as wlevel.
REQ-024 wfull, walmost_full and wlevel SHALL be pessimistic: they deassert or decrease only after RSW2_ptr advances, with 1 wclk edge of latency after the change.
REQ-025 woverflow sets on an edge where winc & wfull; it clears on an edge where woverflow_clr=1 and no set condition exists; set SHALL win when both occur.
REQ-026 Simultaneous accepted write and RSW2_ptr advance: level is computed from both new values, so the net level is unchanged.
REQ-027 The block SHALL contain no combinational path from RSW2_ptr to any output except through registers; wen depends only on winc and wfull.

Reset
REQ-028 While wrst=1 (asynchronous): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-029 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a wclk edge; the first write after release goes to waddr 0.
REQ-030 After wrst deasserts, normal operation resumes on the first rising edge of wclk.

Verification (ASIZE=4, AFULL_THRESH=14)
REQ-031 Reset, RSW2_ptr=0, 16 consecutive writes -> after the 16th edge: wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
REQ-032 From full, winc=1 for 1 cycle -> wen=0, wptr stays 5'b11000, woverflow=1; woverflow_clr pulse -> woverflow=0 next edge.
REQ-033 Reset, 14 writes -> walmost_full=1 after the 14th edge, with wlevel=14 and wfull=0; at 13 writes walmost_full=0.
REQ-034 Full state, RSW2_ptr changes 00000 -> 00001 -> next edge: wfull=0, wlevel=15; one further write -> wfull=1.
REQ-035 Streaming with RSW2_ptr tracking at lag 2 -> wptr passes 5'b10000 (bin 31) to 00000 (bin 0) with a single-bit change, and wfull never asserts.
REQ-036 wrst pulsed between edges while wlevel=9 and woverflow=1 -> all outputs read 0 before the next wclk edge.

Source files
------------

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - FIFO write-side pointer, full/almost-full, fill level and overflow tracking
module wptr_full #(
   parameter int ASIZE        = 4,
   parameter int AFULL_THRESH = (1 << ASIZE) - 2
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic             winc,
   input  logic [ASIZE:0]   RSW2_ptr,
   input  logic             woverflow_clr,
   output logic [ASIZE:0]   wptr,
   output logic [ASIZE-1:0] waddr,
   output logic             wen,
   output logic             wfull,
   output logic             walmost_full,
   output logic [ASIZE:0]   wlevel,
   output logic             woverflow
);

   localparam logic [ASIZE:0] AFULL_LVL = AFULL_THRESH[ASIZE:0];

   logic [ASIZE:0] wbin;
   logic [ASIZE:0] wbinnext;
   logic [ASIZE:0] wgraynext;
   logic [ASIZE:0] rbin_s;
   logic [ASIZE:0] level_next;
   logic           wfull_next;

   assign wen       = winc & ~wfull;
   assign waddr     = wbin[ASIZE-1:0];
   assign wbinnext  = wbin + {{ASIZE{1'b0}}, wen};
   assign wgraynext = (wbinnext >> 1) ^ wbinnext;

   // Each binary bit is the XOR of all Gray bits at and above it.
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i <= ASIZE; i++) begin
         rbin_s[i] = ^(RSW2_ptr >> i);
      end
   end

   assign level_next = wbinnext - rbin_s;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign wfull_next = (wgraynext == {~RSW2_ptr[ASIZE:ASIZE-1], RSW2_ptr[ASIZE-2:0]});

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         woverflow    <= 1'b0;
      end else begin
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= wfull_next;
         walmost_full <= (level_next >= AFULL_LVL);
         wlevel       <= level_next;
         if (winc && wfull) begin
            woverflow <= 1'b1;
         end else if (woverflow_clr) begin
            woverflow <= 1'b0;
         end
      end
   end

endmodule
